// File: rtl/alu_arbiter.sv
// Shared-ALU arbiter: round-robin selects one requester per cycle, computes on a
// single alu instance and holds result/flags/id in a one-entry valid/ready register.

package rvcpu;
  typedef enum logic [3:0] {
    alu_add,
    alu_sub,
    alu_and,
    alu_or,
    alu_xor,
    alu_sll,
    alu_srl,
    alu_sra,
    alu_slt,
    alu_sltu
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;
endpackage

module alu #(
  parameter int Width = 32
) (
  input  rvcpu::alu_op_t    op_i,
  input  logic [Width-1:0]  a_i,
  input  logic [Width-1:0]  b_i,
  output logic [Width-1:0]  res_o,
  output rvcpu::alu_flags_t flags_o
);
  localparam int ShW = $clog2(Width);

  logic signed [Width-1:0] a_s;
  logic signed [Width-1:0] b_s;
  logic        [Width-1:0] b_eff;
  logic                    cin;
  logic        [Width:0]   sum_ext;
  logic        [ShW-1:0]   shamt;
  logic        [Width-1:0] res;
  logic                    carry;
  logic                    ovf;

  assign a_s   = a_i;
  assign b_s   = b_i;
  assign shamt = b_i[ShW-1:0];

  always_comb begin
    b_eff = b_i;
    cin   = 1'b0;
    // Subtraction is a + ~b + 1, so carry out means "no borrow".
    if (op_i == rvcpu::alu_sub) begin
      b_eff = ~b_i;
      cin   = 1'b1;
    end
    sum_ext = {1'b0, a_i} + {1'b0, b_eff} + {{Width{1'b0}}, cin};
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op_i)
      rvcpu::alu_add, rvcpu::alu_sub: begin
        res   = sum_ext[Width-1:0];
        carry = sum_ext[Width];
        ovf   = (a_i[Width-1] == b_eff[Width-1]) && (res[Width-1] != a_i[Width-1]);
      end
      rvcpu::alu_and:  res = a_i & b_i;
      rvcpu::alu_or:   res = a_i | b_i;
      rvcpu::alu_xor:  res = a_i ^ b_i;
      rvcpu::alu_sll:  res = a_i << shamt;
      rvcpu::alu_srl:  res = a_i >> shamt;
      rvcpu::alu_sra:  res = a_s >>> shamt;
      rvcpu::alu_slt:  res = {{(Width-1){1'b0}}, (a_s < b_s)};
      rvcpu::alu_sltu: res = {{(Width-1){1'b0}}, (a_i < b_i)};
      default:         res = '0;
    endcase
  end

  assign res_o            = res;
  assign flags_o.zero     = (res == '0);
  assign flags_o.carry    = carry;
  assign flags_o.negative = res[Width-1];
  assign flags_o.overflow = ovf;
endmodule

module alu_arbiter #(
  parameter int Width  = 32,
  parameter int NumReq = 2,
  parameter int IdW    = $clog2(NumReq)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic              [NumReq-1:0]      req_valid,
  output logic              [NumReq-1:0]      req_ready,
  input  rvcpu::alu_op_t    [NumReq-1:0]      req_op,
  input  logic              [NumReq-1:0][Width-1:0] req_a,
  input  logic              [NumReq-1:0][Width-1:0] req_b,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic              [Width-1:0]       rsp_res,
  output rvcpu::alu_flags_t                   rsp_flags,
  output logic              [IdW-1:0]         rsp_id
);
  typedef enum logic {EMPTY, FULL} occ_e;

  occ_e              state_q, state_d;
  logic [IdW-1:0]    prio_q, prio_d;
  logic [Width-1:0]  res_q;
  rvcpu::alu_flags_t flags_q;
  logic [IdW-1:0]    id_q;

  logic              gnt_valid;
  logic [IdW-1:0]    gnt_idx;
  logic [IdW:0]      scan_idx;
  logic              out_free;
  logic              fire;

  rvcpu::alu_op_t    alu_op;
  logic [Width-1:0]  alu_a;
  logic [Width-1:0]  alu_b;
  logic [Width-1:0]  alu_res;
  rvcpu::alu_flags_t alu_flags;

  // Round-robin scan starting at prio; depends only on req_valid and prio_q.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NumReq; k++) begin
      scan_idx = {1'b0, prio_q} + (IdW+1)'(k);
      if (scan_idx >= (IdW+1)'(NumReq)) scan_idx = scan_idx - (IdW+1)'(NumReq);
      if (!gnt_valid && req_valid[scan_idx[IdW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx[IdW-1:0];
      end
    end
  end

  assign out_free = (state_q == EMPTY) || rsp_ready;
  assign fire     = rst_n && gnt_valid && out_free;

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[gnt_idx] = 1'b1;
  end

  assign alu_op = req_op[gnt_idx];
  assign alu_a  = req_a[gnt_idx];
  assign alu_b  = req_b[gnt_idx];

  alu #(.Width(Width)) u_alu (
    .op_i    (alu_op),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (fire) begin
      state_d = FULL;
      prio_d  = (gnt_idx == IdW'(NumReq-1)) ? '0 : gnt_idx + 1'b1;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prio_q  <= '0;
      res_q   <= '0;
      flags_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (fire) begin
        res_q   <= alu_res;
        flags_q <= alu_flags;
        id_q    <= gnt_idx;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester instance and a 3-requester instance.

module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]             v2, rdy2;
  rvcpu::alu_op_t [1:0]   op2;
  logic [1:0][31:0]       a2, b2;
  logic                   rr2, rv2;
  logic [31:0]            res2;
  rvcpu::alu_flags_t      fl2;
  logic [0:0]             id2;

  logic [2:0]             v3, rdy3;
  rvcpu::alu_op_t [2:0]   op3;
  logic [2:0][31:0]       a3, b3;
  logic                   rr3, rv3;
  logic [31:0]            res3;
  rvcpu::alu_flags_t      fl3;
  logic [1:0]             id3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.Width(32), .NumReq(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2), .req_op(op2),
    .req_a(a2), .req_b(b2), .rsp_valid(rv2), .rsp_ready(rr2), .rsp_res(res2),
    .rsp_flags(fl2), .rsp_id(id2)
  );

  alu_arbiter #(.Width(32), .NumReq(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_op(op3),
    .req_a(a3), .req_b(b3), .rsp_valid(rv3), .rsp_ready(rr3), .rsp_res(res3),
    .rsp_flags(fl3), .rsp_id(id3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    v2 = '0; rr2 = 1'b0; a2 = '0; b2 = '0;
    op2[0] = rvcpu::alu_add; op2[1] = rvcpu::alu_add;
    v3 = '0; rr3 = 1'b0; a3 = '0; b3 = '0;
    op3[0] = rvcpu::alu_add; op3[1] = rvcpu::alu_add; op3[2] = rvcpu::alu_add;

    // Reset state, including req_ready gated while rst_n is low
    #2;
    v2 = 2'b11; v3 = 3'b111;
    #1;
    check("rst_valid", rv2, 0);
    check("rst_res", res2, 0);
    check("rst_id", id2, 0);
    check("rst_flags", fl2, 0);
    check("rst_ready2", rdy2, 0);
    check("rst_ready3", rdy3, 0);
    step();
    check("rst_valid_edge", rv2, 0);
    v2 = '0; v3 = '0;
    rst_n = 1'b1;

    // Requester 0: add 5+7
    op2[0] = rvcpu::alu_add; a2[0] = 32'd5; b2[0] = 32'd7;
    v2 = 2'b01; rr2 = 1'b1;
    #1;
    check("add_ready", rdy2, 2'b01);
    step();
    v2 = '0;
    check("add_valid", rv2, 1);
    check("add_res", res2, 12);
    check("add_id", id2, 0);
    check("add_zero", fl2.zero, 0);
    check("add_carry", fl2.carry, 0);

    // Requester 1: sub 3-3
    op2[1] = rvcpu::alu_sub; a2[1] = 32'd3; b2[1] = 32'd3;
    v2 = 2'b10;
    #1;
    check("sub_ready", rdy2, 2'b10);
    step();
    v2 = '0;
    check("sub_res", res2, 0);
    check("sub_zero", fl2.zero, 1);
    check("sub_carry", fl2.carry, 1);
    check("sub_id", id2, 1);
    step();
    check("drain_valid", rv2, 0);
    check("drain_res_hold", res2, 0);

    // Both valid: grants alternate 0,1,0,1
    op2[0] = rvcpu::alu_add; a2[0] = 32'd1;  b2[0] = 32'd1;
    op2[1] = rvcpu::alu_sub; a2[1] = 32'd10; b2[1] = 32'd4;
    v2 = 2'b11;
    #1;
    check("alt_ready0", rdy2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step();
      check("alt_valid", rv2, 1);
      check("alt_id", id2, i % 2);
      check("alt_res", res2, (i % 2) ? 6 : 2);
      if (i < 3) check("alt_ready", rdy2, (i % 2) ? 2'b01 : 2'b10);
    end

    // Hold with rsp_ready low while requester 1 waits
    v2 = 2'b10;
    op2[1] = rvcpu::alu_xor; a2[1] = 32'hFF; b2[1] = 32'h0F;
    rr2 = 1'b0;
    #1;
    check("hold_ready0", rdy2, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", rv2, 1);
      check("hold_res", res2, 6);
      check("hold_id", id2, 1);
      check("hold_ready", rdy2, 0);
    end
    rr2 = 1'b1;
    #1;
    check("release_ready", rdy2, 2'b10);
    step();
    v2 = '0;
    check("release_res", res2, 32'hF0);
    check("release_id", id2, 1);
    check("release_valid", rv2, 1);

    // Asynchronous reset while FULL
    v2 = 2'b11; rr2 = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rv2, 0);
    check("mid_rst_res", res2, 0);
    check("mid_rst_ready", rdy2, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", rdy2, 2'b01);
    step();
    check("post_rst_id", id2, 0);
    check("post_rst_res", res2, 2);
    check("post_rst_full_ready", rdy2, 0);

    // Single active requester, every cycle, with carry-out wrap
    v2 = 2'b01; rr2 = 1'b1;
    op2[0] = rvcpu::alu_add; a2[0] = 32'hFFFF_FFFF; b2[0] = 32'd1;
    #1;
    check("single_ready", rdy2, 2'b01);
    step();
    check("single_res", res2, 0);
    check("single_zero", fl2.zero, 1);
    check("single_carry", fl2.carry, 1);
    check("single_id", id2, 0);
    check("single_no_bubble", rdy2, 2'b01);
    step();
    check("single_valid2", rv2, 1);
    v2 = '0;

    // NumReq=3: requester 2 xor, then prio wraps to 0
    op3[2] = rvcpu::alu_xor; a3[2] = 32'hF0F0_F0F0; b3[2] = 32'hFFFF_FFFF;
    v3 = 3'b100; rr3 = 1'b1;
    #1;
    check("n3_ready2", rdy3, 3'b100);
    step();
    check("n3_res", res3, 32'h0F0F_0F0F);
    check("n3_id", id3, 2);
    check("n3_valid", rv3, 1);
    v3 = 3'b111;
    #1;
    check("n3_wrap_ready", rdy3, 3'b001);
    step();
    v3 = '0;
    check("n3_wrap_id", id3, 0);
    check("n3_wrap_res", res3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
